// File: rtl/demux12_pkg.sv
// Shared definitions for the demux12_pipe 1:2 router: channel select codes
// and the FIFO pointer-width helper.
package demux12_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int PTR_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ch.sv
// Single-clock per-channel FIFO with wrap-bit pointers; storage is not reset,
// only the pointers are.
module sync_fifo_ch
  import demux12_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PW = PTR_W(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_ch: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             push_en;
  logic             pop_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

  // Guard locally as well so a misbehaving parent cannot corrupt the pointers.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/demux12_pipe.sv
// 1:2 valid/ready router with a FIFO per channel. Define DEMUX12_PIPE_STATS_EN
// to add per-channel 32-bit pop counters (cnt0/cnt1).
module demux12_pipe
  import demux12_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX12_PIPE_STATS_EN
  ,
  output logic [31:0]      cnt0,
  output logic [31:0]      cnt1
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // ready never depends on valid, and valid/data hold while valid && !ready.

  logic             full0, full1;
  logic             empty0, empty1;
  logic [WIDTH-1:0] head0, head1;
  logic             push0, push1;
  logic             pop0, pop1;

  assign in_ready = (in_sel == CH1) ? !full1 : !full0;

  assign push0 = in_valid && in_ready && (in_sel == CH0);
  assign push1 = in_valid && in_ready && (in_sel == CH1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign out0_data  = empty0 ? '0 : head0;
  assign out1_data  = empty1 ? '0 : head1;

  assign pop0 = out0_valid && out0_ready;
  assign pop1 = out1_valid && out1_ready;

  sync_fifo_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push0),
    .push_data(in_data),
    .pop      (pop0),
    .full     (full0),
    .empty    (empty0),
    .head_data(head0)
  );

  sync_fifo_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push1),
    .push_data(in_data),
    .pop      (pop1),
    .full     (full1),
    .empty    (empty1),
    .head_data(head1)
  );

`ifdef DEMUX12_PIPE_STATS_EN
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + 32'd1;
    if (pop1) cnt1_d = cnt1_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
